// File: rtl/traffic_light_monitor.sv
// Safety monitor for the red/yellow/green lamp interface.
// Tracks phase and dwell, flags one-hot/order/duration faults, counts cycles.
//
// Ports:
//   clk, reset (sync, active-low)
//   red, yellow, green : lamp lines, sampled every rising edge
//   clr_err            : clears err_sticky (a new error in the same cycle wins)
//   phase              : 0=NONE 1=GREEN 2=YELLOW 3=RED
//   dwell              : consecutive samples of current lamp (saturating)
//   err_onehot/seq/dur : one-cycle error pulses
//   err_sticky         : OR of all error pulses since the last clear
//   cycle_cnt          : legal R->G transitions (wrapping)
module traffic_light_monitor #(
   parameter int CNT_W = 8,
   parameter int CYC_W = 16,
   parameter int G_MIN = 4,
   parameter int G_MAX = 8,
   parameter int Y_MIN = 2,
   parameter int Y_MAX = 3,
   parameter int R_MIN = 4,
   parameter int R_MAX = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   input  logic             clr_err,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] dwell,
   output logic             err_onehot,
   output logic             err_seq,
   output logic             err_dur,
   output logic             err_sticky,
   output logic [CYC_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      PH_NONE   = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2,
      PH_RED    = 2'd3
   } phase_e;

   localparam logic [CNT_W-1:0] DWELL_SAT = '1;

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             first_q, first_d;
   logic             err_onehot_q, err_onehot_d;
   logic             err_seq_q, err_seq_d;
   logic             err_dur_q, err_dur_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

   logic             onehot;
   phase_e           lamp;
   phase_e           succ;
   logic [CNT_W-1:0] dmin;
   logic [CNT_W-1:0] dmax;

   // Decode the sampled lamp pattern.
   always_comb begin
      onehot = ({red, yellow, green} == 3'b100) ||
               ({red, yellow, green} == 3'b010) ||
               ({red, yellow, green} == 3'b001);
      lamp = PH_NONE;
      if (onehot) begin
         unique case (1'b1)
            green:  lamp = PH_GREEN;
            yellow: lamp = PH_YELLOW;
            red:    lamp = PH_RED;
         endcase
      end
   end

   // Legal successor and dwell bounds of the phase being occupied.
   always_comb begin
      succ = PH_NONE;
      dmin = '0;
      dmax = '0;
      case (phase_q)
         PH_GREEN: begin
            succ = PH_YELLOW;
            dmin = CNT_W'(G_MIN);
            dmax = CNT_W'(G_MAX);
         end
         PH_YELLOW: begin
            succ = PH_RED;
            dmin = CNT_W'(Y_MIN);
            dmax = CNT_W'(Y_MAX);
         end
         PH_RED: begin
            succ = PH_GREEN;
            dmin = CNT_W'(R_MIN);
            dmax = CNT_W'(R_MAX);
         end
         default: begin
            succ = PH_NONE;
            dmin = '0;
            dmax = '0;
         end
      endcase
   end

   always_comb begin
      phase_d      = phase_q;
      dwell_d      = dwell_q;
      first_d      = first_q;
      err_onehot_d = 1'b0;
      err_seq_d    = 1'b0;
      err_dur_d    = 1'b0;
      cycle_cnt_d  = cycle_cnt_q;

      if (!onehot) begin
         err_onehot_d = 1'b1;
         phase_d      = PH_NONE;
         dwell_d      = '0;
         first_d      = 1'b1;
      end else if (phase_q == PH_NONE) begin
         // Resync: join mid-phase without judging it.
         phase_d = lamp;
         dwell_d = CNT_W'(1);
         first_d = 1'b1;
      end else if (lamp == phase_q) begin
         if (dwell_q != DWELL_SAT) begin
            dwell_d = dwell_q + CNT_W'(1);
         end
         // Dwell passes MAX exactly once per occupancy since MAX < saturation.
         if (dwell_q == dmax) begin
            err_dur_d = 1'b1;
         end
      end else if (lamp == succ) begin
         // A timed-out phase has dwell > MAX >= MIN, so no second pulse here.
         err_dur_d = (dwell_q < dmin) && !first_q;
         phase_d   = lamp;
         dwell_d   = CNT_W'(1);
         first_d   = 1'b0;
         if (phase_q == PH_RED) begin
            cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
         end
      end else begin
         err_seq_d = 1'b1;
         phase_d   = lamp;
         dwell_d   = CNT_W'(1);
         first_d   = 1'b1;
      end

      err_sticky_d = (err_sticky_q && !clr_err) ||
                     err_onehot_d || err_seq_d || err_dur_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q      <= PH_NONE;
         dwell_q      <= '0;
         first_q      <= 1'b1;
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
         err_dur_q    <= 1'b0;
         err_sticky_q <= 1'b0;
         cycle_cnt_q  <= '0;
      end else begin
         phase_q      <= phase_d;
         dwell_q      <= dwell_d;
         first_q      <= first_d;
         err_onehot_q <= err_onehot_d;
         err_seq_q    <= err_seq_d;
         err_dur_q    <= err_dur_d;
         err_sticky_q <= err_sticky_d;
         cycle_cnt_q  <= cycle_cnt_d;
      end
   end

   assign phase      = phase_q;
   assign dwell      = dwell_q;
   assign err_onehot = err_onehot_q;
   assign err_seq    = err_seq_q;
   assign err_dur    = err_dur_q;
   assign err_sticky = err_sticky_q;
   assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor.
// Directed scenarios plus random lamp traffic against a behavioural model.
module tb_traffic_light_monitor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        red, yellow, green, clr_err;
   logic [1:0]  phase;
   logic [7:0]  dwell;
   logic        err_onehot, err_seq, err_dur, err_sticky;
   logic [15:0] cycle_cnt;

   always #5 clk = ~clk;

   traffic_light_monitor dut (
      .clk        (clk),
      .reset      (reset_n),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .clr_err    (clr_err),
      .phase      (phase),
      .dwell      (dwell),
      .err_onehot (err_onehot),
      .err_seq    (err_seq),
      .err_dur    (err_dur),
      .err_sticky (err_sticky),
      .cycle_cnt  (cycle_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model state: phase as 0..3, plain integer dwell and cycle count.
   int m_phase, m_dwell, m_first, m_cyc;
   bit e_oh, e_seq, e_dur, e_st;
   int min_t[4] = '{0, 4, 2, 4};
   int max_t[4] = '{0, 8, 3, 8};

   task automatic check(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int n, l;
      if (!reset_n) begin
         m_phase = 0; m_dwell = 0; m_first = 1; m_cyc = 0;
         e_oh = 0; e_seq = 0; e_dur = 0; e_st = 0;
         return;
      end
      e_oh = 0; e_seq = 0; e_dur = 0;
      n = int'(red) + int'(yellow) + int'(green);
      if (n != 1) begin
         e_oh = 1; m_phase = 0; m_dwell = 0; m_first = 1;
      end else begin
         l = green ? 1 : (yellow ? 2 : 3);
         if (m_phase == 0) begin
            m_phase = l; m_dwell = 1; m_first = 1;
         end else if (l == m_phase) begin
            if (m_dwell < 255) begin
               m_dwell++;
               if (m_dwell == max_t[m_phase] + 1) e_dur = 1;
            end
         end else if (l == (m_phase % 3) + 1) begin
            e_dur = (m_dwell < min_t[m_phase]) && (m_first == 0);
            if (m_phase == 3) m_cyc = (m_cyc + 1) % 65536;
            m_phase = l; m_dwell = 1; m_first = 0;
         end else begin
            e_seq = 1; m_phase = l; m_dwell = 1; m_first = 1;
         end
      end
      e_st = (e_st && !clr_err) || e_oh || e_seq || e_dur;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("phase", int'(phase), m_phase);
         check("dwell", int'(dwell), m_dwell);
         check("err_onehot", int'(err_onehot), int'(e_oh));
         check("err_seq", int'(err_seq), int'(e_seq));
         check("err_dur", int'(err_dur), int'(e_dur));
         check("err_sticky", int'(err_sticky), int'(e_st));
         check("cycle_cnt", int'(cycle_cnt), m_cyc);
      end
   end

   task automatic apply(bit rn, logic [2:0] ryg, bit c);
      @(negedge clk);
      reset_n = rn;
      {red, yellow, green} = ryg;
      clr_err = c;
      @(posedge clk);
      #1;
      model_step();
      chk_en = 1'b1;
   endtask

   function automatic logic [2:0] code(int l);
      case (l)
         1:       return 3'b001;
         2:       return 3'b010;
         3:       return 3'b100;
         4:       return 3'b011;
         default: return 3'b000;
      endcase
   endfunction

   task automatic lamp(int l, int n, bit c = 1'b0);
      repeat (n) apply(1'b1, code(l), c);
   endtask

   task automatic do_reset(int n);
      repeat (n) apply(1'b0, 3'b111, 1'b0);
   endtask

   localparam int G = 1, Y = 2, R = 3;

   initial begin
      reset_n = 1'b0;
      {red, yellow, green} = 3'b111;
      clr_err = 1'b0;

      // Reset with all lamps high.
      do_reset(2);
      check("rst_phase", int'(phase), 0);
      check("rst_dwell", int'(dwell), 0);
      check("rst_cyc", int'(cycle_cnt), 0);
      check("rst_sticky", int'(err_sticky), 0);

      // Legal loop.
      lamp(G, 5);
      check("loop_g_dwell", int'(dwell), 5);
      lamp(Y, 2);
      check("loop_y", int'(phase), 2);
      lamp(R, 5);
      check("loop_r", int'(phase), 3);
      check("loop_cyc0", int'(cycle_cnt), 0);
      lamp(G, 1);
      check("loop_g", int'(phase), 1);
      check("loop_cyc1", int'(cycle_cnt), 1);
      check("loop_sticky", int'(err_sticky), 0);

      // Partial first phase is not judged against MIN.
      do_reset(1);
      lamp(G, 1);
      lamp(Y, 2);
      lamp(R, 4);
      lamp(G, 1);
      check("first_cyc", int'(cycle_cnt), 1);
      check("first_sticky", int'(err_sticky), 0);

      // Short yellow.
      lamp(G, 4);
      lamp(Y, 1);
      lamp(R, 1);
      check("short_y_dur", int'(err_dur), 1);
      check("short_y_st", int'(err_sticky), 1);
      lamp(R, 3);
      check("short_y_dur0", int'(err_dur), 0);
      check("short_y_st1", int'(err_sticky), 1);
      lamp(R, 1, 1'b1);
      check("clr_st", int'(err_sticky), 0);

      // Green timeout.
      do_reset(1);
      lamp(R, 4);
      lamp(G, 8);
      check("to_dur8", int'(err_dur), 0);
      lamp(G, 1);
      check("to_dur9", int'(err_dur), 1);
      check("to_dwell9", int'(dwell), 9);
      lamp(G, 1);
      check("to_dur10", int'(err_dur), 0);
      lamp(G, 2);
      lamp(Y, 1);
      check("to_exit", int'(err_dur), 0);
      check("to_cyc", int'(cycle_cnt), 1);

      // Bad pattern then bad order.
      lamp(4, 1);
      check("oh_err", int'(err_onehot), 1);
      check("oh_phase", int'(phase), 0);
      lamp(G, 5);
      lamp(R, 1);
      check("seq_err", int'(err_seq), 1);
      check("seq_phase", int'(phase), 3);
      check("seq_cyc", int'(cycle_cnt), 1);

      // Error wins over clear in the same cycle.
      lamp(R, 1, 1'b1);
      check("pre_clr", int'(err_sticky), 0);
      lamp(Y, 1, 1'b1);
      check("clr_seq_err", int'(err_seq), 1);
      check("clr_seq_st", int'(err_sticky), 1);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         int sel, nxt, len;
         logic [2:0] pat;
         sel = $urandom_range(0, 99);
         if (sel < 2) begin
            do_reset($urandom_range(1, 2));
         end else if (sel < 8) begin
            do begin
               pat = 3'($urandom_range(0, 7));
            end while ($countones(pat) == 1);
            apply(1'b1, pat, $urandom_range(0, 9) == 0);
         end else begin
            if (m_phase != 0 && $urandom_range(0, 3) != 0)
               nxt = (m_phase % 3) + 1;
            else
               nxt = $urandom_range(1, 3);
            len = $urandom_range(1, 12);
            repeat (len)
               apply(1'b1, code(nxt), $urandom_range(0, 19) == 0);
         end
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
